// File: rtl/simple_read_burst_split_if.sv
// Bus bundle for simple_read_burst_split: upstream read request/response and downstream
// sub-burst request/response. Signal suffixes are from the splitter's point of view.
`timescale 1ns / 1ps
interface simple_read_burst_split_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 20
);
  logic              s_req_valid_i;
  logic              s_req_ready_o;
  logic [ADDR_W-1:0] s_addr_i;
  logic [LEN_W-1:0]  s_len_i;
  logic              s_rvalid_o;
  logic [DATA_W-1:0] s_rdata_o;
  logic              s_rlast_o;
  logic              m_req_valid_o;
  logic              m_req_ready_i;
  logic [ADDR_W-1:0] m_addr_o;
  logic [LEN_W-1:0]  m_len_o;
  logic              m_rvalid_i;
  logic [DATA_W-1:0] m_rdata_i;
  logic              m_rlast_i;
  logic              err_o;

  // The splitter itself.
  modport master (
    input  s_req_valid_i, s_addr_i, s_len_i, m_req_ready_i, m_rvalid_i, m_rdata_i, m_rlast_i,
    output s_req_ready_o, s_rvalid_o, s_rdata_o, s_rlast_o, m_req_valid_o, m_addr_o, m_len_o,
           err_o
  );

  // The surrounding environment (upstream requester plus downstream converter).
  modport slave (
    output s_req_valid_i, s_addr_i, s_len_i, m_req_ready_i, m_rvalid_i, m_rdata_i, m_rlast_i,
    input  s_req_ready_o, s_rvalid_o, s_rdata_o, s_rlast_o, m_req_valid_o, m_addr_o, m_len_o,
           err_o
  );
endinterface

// File: rtl/simple_read_burst_split.sv
// Splits a byte-length read request into sub-bursts that never cross a 4 KiB page and never
// exceed MAX_BEATS beats. Optional request checking is enabled by VERSAT_SPLIT_CHECK_EN.
`timescale 1ns / 1ps
module simple_read_burst_split #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LEN_W     = 20,
  parameter int unsigned MAX_BEATS = 256
) (
  input logic                       clk_i,
  input logic                       arst_n_i,
  simple_read_burst_split_if.master bus
);

  localparam int unsigned B        = DATA_W / 8;
  localparam int unsigned MaxBytes = MAX_BEATS * B;
  localparam int unsigned LenW1    = LEN_W + 1;
  localparam int unsigned MaxW     = $clog2(MaxBytes) + 1;
  // Wide enough for remaining, the 4096-byte page room and the beat cap at once.
  localparam int unsigned CalcW0   = (LenW1 > 14) ? LenW1 : 14;
  localparam int unsigned CalcW    = (CalcW0 > MaxW) ? CalcW0 : MaxW;

  typedef enum logic [1:0] {StIdle, StIssue, StData} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  logic [CalcW-1:0]  rem_ext, page_room, max_room, sub_ext;
  logic [LEN_W-1:0]  sub_len, rem_left;
  logic              illegal;

  logic              s_req_ready, s_rvalid, s_rlast, m_req_valid, err;
  logic [DATA_W-1:0] s_rdata;
  logic [ADDR_W-1:0] m_addr;
  logic [LEN_W-1:0]  m_len;

  assign rem_ext   = CalcW'(rem_q);
  assign page_room = CalcW'(13'h1000 - {1'b0, addr_q[11:0]});
  assign max_room  = CalcW'(MaxBytes);

  always_comb begin
    sub_ext = rem_ext;
    if (page_room < sub_ext) sub_ext = page_room;
    if (max_room < sub_ext)  sub_ext = max_room;
  end

  // Never wider than remaining, so the narrowing cast is lossless.
  assign sub_len  = LEN_W'(sub_ext);
  assign rem_left = rem_q - sub_len;

`ifdef VERSAT_SPLIT_CHECK_EN
  localparam logic [ADDR_W-1:0] AddrMask = ADDR_W'(B - 1);
  localparam logic [LEN_W-1:0]  LenMask  = LEN_W'(B - 1);

  assign illegal = (bus.s_len_i == '0) || ((bus.s_addr_i & AddrMask) != '0) ||
                   ((bus.s_len_i & LenMask) != '0);
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    s_req_ready = 1'b0;
    err         = 1'b0;
    m_req_valid = 1'b0;
    m_addr      = '0;
    m_len       = '0;
    s_rvalid    = 1'b0;
    s_rdata     = '0;
    s_rlast     = 1'b0;

    case (state_q)
      StIdle: begin
        // Reset gating keeps the accept pulse low while reset is held.
        if (bus.s_req_valid_i && arst_n_i) begin
          s_req_ready = 1'b1;
          if (illegal) begin
            err = 1'b1;
          end else begin
            addr_d  = bus.s_addr_i;
            rem_d   = bus.s_len_i;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        m_req_valid = 1'b1;
        m_addr      = addr_q;
        m_len       = sub_len;
        if (bus.m_req_ready_i) state_d = StData;
      end
      StData: begin
        s_rvalid = bus.m_rvalid_i;
        s_rdata  = bus.m_rdata_i;
        if (bus.m_rvalid_i && bus.m_rlast_i) begin
          rem_d  = rem_left;
          addr_d = addr_q + ADDR_W'(sub_len);
          if (rem_left == '0) begin
            s_rlast = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.s_req_ready_o = s_req_ready;
  assign bus.s_rvalid_o    = s_rvalid;
  assign bus.s_rdata_o     = s_rdata;
  assign bus.s_rlast_o     = s_rlast;
  assign bus.m_req_valid_o = m_req_valid;
  assign bus.m_addr_o      = m_addr;
  assign bus.m_len_o       = m_len;
  assign bus.err_o         = err;

endmodule
